// File: rtl/link_train_ctrl.sv
// ============================================================================
// link_train_ctrl : training sequencer for the receive word aligner
//   Optional: LINK_TRAIN_AUTORETRY_EN enables a timed backoff exit from FAIL.
//   Rev 1.0 - initial release
// ============================================================================
`default_nettype none

module link_train_ctrl #(
  parameter int          INIT_CYC  = 16,
  parameter int          ALIGN_TO  = 1024,
  parameter int          VERIFY_N  = 4,
  parameter int          MAX_RETRY = 3,
  parameter logic [31:0] SYNC_WORD = 32'hF731_8CEF
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        start_i,
  input  logic        relink_i,
  input  logic        aligned_i,
  input  logic        dipush_i,
  input  logic [31:0] din_i,
  output logic        phy_init_o,
  output logic        tx_train_o,
  output logic        dopush_o,
  output logic [31:0] dout_o,
  output logic        link_up_o,
  output logic        link_fail_o,
  output logic [3:0]  retry_cnt_o
);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_INIT   = 3'd1;
  localparam logic [2:0] S_WAIT   = 3'd2;
  localparam logic [2:0] S_VERIFY = 3'd3;
  localparam logic [2:0] S_RETRY  = 3'd4;
  localparam logic [2:0] S_LINKUP = 3'd5;
  localparam logic [2:0] S_FAIL   = 3'd6;

`ifdef LINK_TRAIN_AUTORETRY_EN
  localparam int BACKOFF_CYC = 4 * ALIGN_TO;
`else
  localparam int BACKOFF_CYC = 1;
`endif

  // One shared state timer, sized for the longest interval it must measure.
  localparam int T_SPAN = (ALIGN_TO > INIT_CYC) ? ALIGN_TO : INIT_CYC;
  localparam int T_LIM  = (BACKOFF_CYC > T_SPAN) ? BACKOFF_CYC : T_SPAN;
  localparam int TW     = $clog2(T_LIM) + 1;
  localparam int MW     = $clog2(VERIFY_N + 1);

  localparam logic [TW-1:0] INIT_END    = TW'(INIT_CYC - 1);
  localparam logic [TW-1:0] ALIGN_END   = TW'(ALIGN_TO - 1);
  localparam logic [TW-1:0] BACKOFF_END = TW'(BACKOFF_CYC - 1);
  localparam logic [MW-1:0] VERIFY_LAST = MW'(VERIFY_N - 1);
  localparam logic [3:0]    RETRY_LIM   = 4'(MAX_RETRY);

  logic [2:0]    state_q, state_d;
  logic [TW-1:0] timer_q, timer_d;
  logic [MW-1:0] match_q, match_d;
  logic [3:0]    retry_q, retry_d;
  logic          start_q;
  logic          phy_init_q, phy_init_d;
  logic          tx_train_q, tx_train_d;
  logic          link_up_q, link_up_d;
  logic          link_fail_q, link_fail_d;
  logic          dopush_q, dopush_d;
  logic [31:0]   dout_q, dout_d;

  logic start_rise;
  assign start_rise = start_i & ~start_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= S_IDLE;
      timer_q     <= '0;
      match_q     <= '0;
      retry_q     <= '0;
      start_q     <= 1'b0;
      phy_init_q  <= 1'b0;
      tx_train_q  <= 1'b0;
      link_up_q   <= 1'b0;
      link_fail_q <= 1'b0;
      dopush_q    <= 1'b0;
      dout_q      <= '0;
    end else begin
      state_q     <= state_d;
      timer_q     <= timer_d;
      match_q     <= match_d;
      retry_q     <= retry_d;
      start_q     <= start_i;
      phy_init_q  <= phy_init_d;
      tx_train_q  <= tx_train_d;
      link_up_q   <= link_up_d;
      link_fail_q <= link_fail_d;
      dopush_q    <= dopush_d;
      dout_q      <= dout_d;
    end
  end

  always_comb begin
    state_d = state_q;
    retry_d = retry_q;
    match_d = match_q;
    timer_d = (&timer_q) ? timer_q : timer_q + TW'(1);
    case (state_q)
      S_IDLE: begin
        if (start_rise) begin
          state_d = S_INIT;
          retry_d = '0;
        end
      end
      S_INIT: begin
        if (timer_q == INIT_END) state_d = S_WAIT;
      end
      S_WAIT: begin
        if (aligned_i)                   state_d = S_VERIFY;
        else if (timer_q == ALIGN_END)   state_d = S_RETRY;
      end
      S_VERIFY: begin
        // The idle timeout measures the gap since the most recent aligned word.
        if (dipush_i) begin
          timer_d = '0;
          if (din_i == SYNC_WORD) begin
            if (match_q == VERIFY_LAST) state_d = S_LINKUP;
            else                        match_d = match_q + MW'(1);
          end else begin
            state_d = S_RETRY;
          end
        end else if (timer_q == ALIGN_END) begin
          state_d = S_RETRY;
        end
      end
      S_RETRY: begin
        retry_d = (retry_q == 4'hF) ? retry_q : retry_q + 4'd1;
        state_d = (retry_d >= RETRY_LIM) ? S_FAIL : S_INIT;
      end
      S_LINKUP: begin
        if (relink_i) begin
          state_d = S_INIT;
          retry_d = '0;
        end
      end
      S_FAIL: begin
        if (start_rise) begin
          state_d = S_INIT;
          retry_d = '0;
        end
`ifdef LINK_TRAIN_AUTORETRY_EN
        else if (timer_q == BACKOFF_END) begin
          state_d = S_INIT;
          retry_d = '0;
        end
`endif
      end
      default: state_d = S_IDLE;
    endcase
    if (state_d != state_q) begin
      timer_d = '0;
      match_d = '0;
    end
  end

  // Outputs are registered from the next state so they line up with the state.
  always_comb begin
    phy_init_d  = (state_d == S_INIT);
    tx_train_d  = (state_d == S_INIT) || (state_d == S_WAIT) || (state_d == S_VERIFY);
    link_up_d   = (state_d == S_LINKUP);
    link_fail_d = (state_d == S_FAIL);
    dopush_d    = (state_q == S_LINKUP) && (state_d == S_LINKUP) && dipush_i;
    dout_d      = dopush_d ? din_i : dout_q;
  end

  assign phy_init_o  = phy_init_q;
  assign tx_train_o  = tx_train_q;
  assign link_up_o   = link_up_q;
  assign link_fail_o = link_fail_q;
  assign dopush_o    = dopush_q;
  assign dout_o      = dout_q;
  assign retry_cnt_o = retry_q;

endmodule

`default_nettype wire

// File: tb/tb_link_train_ctrl.sv
// ============================================================================
// tb_link_train_ctrl : directed + randomized bench with a reference model
//   Rev 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_link_train_ctrl;

  localparam int          INIT_CYC  = 16;
  localparam int          ALIGN_TO  = 1024;
  localparam int          VERIFY_N  = 4;
  localparam int          MAX_RETRY = 3;
  localparam logic [31:0] SYNC      = 32'hF731_8CEF;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0, relink = 1'b0, aligned = 1'b0, dipush = 1'b0;
  logic [31:0] din = '0;
  wire         phy_init_o, tx_train_o, dopush_o, link_up_o, link_fail_o;
  wire  [31:0] dout_o;
  wire  [3:0]  retry_cnt_o;

  link_train_ctrl dut (
    .clk_i(clk), .rst_ni(rst_n), .start_i(start), .relink_i(relink),
    .aligned_i(aligned), .dipush_i(dipush), .din_i(din),
    .phy_init_o(phy_init_o), .tx_train_o(tx_train_o), .dopush_o(dopush_o),
    .dout_o(dout_o), .link_up_o(link_up_o), .link_fail_o(link_fail_o),
    .retry_cnt_o(retry_cnt_o)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  typedef enum int {P_IDLE, P_INIT, P_WAIT, P_VER, P_RETRY, P_UP, P_FAIL} ph_t;
  ph_t         m_ph;
  int          m_age, m_hits, m_retries;
  bit          m_prev_start, m_dopush;
  logic [31:0] m_dout;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      if (bad <= 40)
        $display("FAIL %s: got %h expected %h (cycle %0d)", name, got, exp, cyc);
    end
  endtask

  task automatic model_reset();
    m_ph = P_IDLE; m_age = 0; m_hits = 0; m_retries = 0;
    m_prev_start = 1'b0; m_dopush = 1'b0; m_dout = '0;
  endtask

  task automatic model_step();
    ph_t nph;
    bit  rise;
    rise = start && !m_prev_start;
    m_prev_start = start;
    nph = m_ph;
    m_dopush = 1'b0;
    case (m_ph)
      P_IDLE:  if (rise) begin nph = P_INIT; m_retries = 0; end
      P_INIT:  if (m_age == INIT_CYC - 1) nph = P_WAIT;
      P_WAIT:  if (aligned) nph = P_VER; else if (m_age == ALIGN_TO - 1) nph = P_RETRY;
      P_VER: begin
        if (dipush) begin
          if (din == SYNC) begin
            m_hits++;
            if (m_hits == VERIFY_N) nph = P_UP;
          end else nph = P_RETRY;
        end else if (m_age == ALIGN_TO - 1) nph = P_RETRY;
      end
      P_RETRY: begin
        m_retries = (m_retries < 15) ? m_retries + 1 : 15;
        nph = (m_retries >= MAX_RETRY) ? P_FAIL : P_INIT;
      end
      P_UP: begin
        if (relink) begin nph = P_INIT; m_retries = 0; end
        else if (dipush) begin m_dopush = 1'b1; m_dout = din; end
      end
      P_FAIL: begin
        if (rise) begin nph = P_INIT; m_retries = 0; end
`ifdef LINK_TRAIN_AUTORETRY_EN
        else if (m_age == 4 * ALIGN_TO - 1) begin nph = P_INIT; m_retries = 0; end
`endif
      end
      default: nph = P_IDLE;
    endcase
    if (nph != m_ph) begin m_age = 0; m_hits = 0; end
    else if (m_ph == P_VER && dipush) m_age = 0;
    else m_age++;
    m_ph = nph;
  endtask

  task automatic compare_all();
    chk("phy_init",  {31'd0, phy_init_o},  {31'd0, m_ph == P_INIT});
    chk("tx_train",  {31'd0, tx_train_o},  {31'd0, m_ph inside {P_INIT, P_WAIT, P_VER}});
    chk("link_up",   {31'd0, link_up_o},   {31'd0, m_ph == P_UP});
    chk("link_fail", {31'd0, link_fail_o}, {31'd0, m_ph == P_FAIL});
    chk("retry_cnt", {28'd0, retry_cnt_o}, 32'(m_retries));
    chk("dopush",    {31'd0, dopush_o},    {31'd0, m_dopush});
    chk("dout",      dout_o,               m_dout);
  endtask

  task automatic cycle();
    @(posedge clk);
    if (!rst_n) model_reset(); else model_step();
    cyc++;
    #1;
    compare_all();
  endtask

  task automatic chk_all_zero(input string name);
    chk(name, {phy_init_o, tx_train_o, dopush_o, link_up_o, link_fail_o, retry_cnt_o} , '0);
    chk({name, "_dout"}, dout_o, 32'd0);
  endtask

  initial begin
    int phy_cnt, n, t[4];
    logic [31:0] words[3];
    bit seen_up;
    model_reset();
    rst_n = 1'b0;
    repeat (3) cycle();
    chk_all_zero("reset_state");
    rst_n = 1'b1;
    repeat (3) cycle();

    // Happy path
    start = 1'b1; phy_cnt = 0;
    for (int i = 0; i < 30; i++) begin
      cycle();
      if (phy_init_o) phy_cnt++;
    end
    chk("init_pulse_width", 32'(phy_cnt), 32'd16);
    start = 1'b0; aligned = 1'b1;
    cycle();
    aligned = 1'b0; dipush = 1'b1; din = SYNC;
    repeat (4) cycle();
    chk("happy_link_up",  {31'd0, link_up_o},  32'd1);
    chk("happy_retry",    {28'd0, retry_cnt_o}, 32'd0);
    chk("happy_tx_train", {31'd0, tx_train_o}, 32'd0);

    // Payload pass-through then RELINK
    for (int k = 1; k <= 8; k++) begin
      dipush = 1'b1; din = 32'hA5A5_0000 + 32'(k);
      cycle();
      chk("payload_dopush", {31'd0, dopush_o}, 32'd1);
      chk("payload_dout", dout_o, 32'hA5A5_0000 + 32'(k));
    end
    dipush = 1'b0;
    cycle();
    chk("payload_idle_dopush", {31'd0, dopush_o}, 32'd0);
    chk("payload_hold_dout", dout_o, 32'hA5A5_0008);
    relink = 1'b1;
    cycle();
    relink = 1'b0;
    chk("relink_link_up", {31'd0, link_up_o}, 32'd0);
    chk("relink_phy_init", {31'd0, phy_init_o}, 32'd1);

    // Verify mismatch
    n = 0;
    while (m_ph != P_WAIT && n < 100) begin cycle(); n++; end
    aligned = 1'b1;
    cycle();
    aligned = 1'b0;
    words[0] = SYNC; words[1] = SYNC; words[2] = 32'h1234_5678;
    seen_up = 1'b0;
    for (int i = 0; i < 3; i++) begin
      dipush = 1'b1; din = words[i];
      cycle();
      seen_up |= link_up_o;
    end
    dipush = 1'b0;
    cycle();
    seen_up |= link_up_o;
    chk("mismatch_retry", {28'd0, retry_cnt_o}, 32'd1);
    chk("mismatch_phy_init", {31'd0, phy_init_o}, 32'd1);
    chk("mismatch_no_link_up", {31'd0, seen_up}, 32'd0);

    // Timeouts to FAIL
    rst_n = 1'b0; cycle(); rst_n = 1'b1; cycle();
    start = 1'b1; cycle(); start = 1'b0;
    phy_cnt = phy_init_o ? 1 : 0;
    t[0] = cyc; t[1] = 0; t[2] = 0; t[3] = 0;
    n = 0;
    while (m_ph != P_FAIL && n < 4000) begin
      cycle(); n++;
      if (phy_init_o) phy_cnt++;
      if (retry_cnt_o >= 4'd1 && retry_cnt_o <= 4'd3 && t[retry_cnt_o] == 0) t[retry_cnt_o] = cyc;
    end
    chk("timeout_retry_final", {28'd0, retry_cnt_o}, 32'd3);
    chk("timeout_link_fail", {31'd0, link_fail_o}, 32'd1);
    chk("timeout_phy_low", {31'd0, phy_init_o}, 32'd0);
    chk("timeout_phy_total", 32'(phy_cnt), 32'd48);
    chk("timeout_gap_1_2", 32'(t[2] - t[1]), 32'd1041);
    chk("timeout_gap_2_3", 32'(t[3] - t[2]), 32'd1041);

`ifdef LINK_TRAIN_AUTORETRY_EN
    n = 0;
    while (!phy_init_o && n < 5000) begin cycle(); n++; end
    chk("backoff_len", 32'(n), 32'd4096);
    chk("backoff_retry_clear", {28'd0, retry_cnt_o}, 32'd0);
    n = 0;
    while (m_ph != P_FAIL && n < 4000) begin cycle(); n++; end
`else
    repeat (10000) cycle();
    chk("fail_sticky", {31'd0, link_fail_o}, 32'd1);
    chk("fail_phy_low", {31'd0, phy_init_o}, 32'd0);
`endif

    // START edge leaves FAIL
    start = 1'b1;
    cycle();
    start = 1'b0;
    chk("fail_restart_phy", {31'd0, phy_init_o}, 32'd1);
    chk("fail_restart_retry", {28'd0, retry_cnt_o}, 32'd0);

    // Reset on the 5th PHY_INIT cycle
    repeat (4) cycle();
    chk("pre_reset_phy", {31'd0, phy_init_o}, 32'd1);
    #2 rst_n = 1'b0;
    #1 chk_all_zero("async_reset");
    model_reset();
    repeat (2) cycle();
    rst_n = 1'b1;
    n = 0;
    for (int i = 0; i < 20; i++) begin
      cycle();
      if (phy_init_o || tx_train_o) n++;
    end
    chk("post_reset_quiet", 32'(n), 32'd0);

    // Randomized traffic
    for (int i = 0; i < 20000; i++) begin
      if ($urandom_range(0, 199) == 0) start = ~start;
      relink  = ($urandom_range(0, 299) == 0);
      aligned = (((i / 3000) % 3) == 2) ? 1'b0 : ($urandom_range(0, 39) == 0);
      dipush  = ($urandom_range(0, 2) == 0);
      din     = ($urandom_range(0, 15) == 0) ? 32'($urandom) : SYNC;
      cycle();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
